// File: rtl/deriv_seq_ctrl_if.sv
// rtl/deriv_seq_ctrl_if.sv - z/g read port and delta write port bundle
interface deriv_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_z;
  logic [23:0]       rd_g;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_z, rd_g, wr_ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_z, rd_g, wr_ready
  );
endinterface

// File: rtl/deriv_seq_ctrl.sv
// rtl/deriv_seq_ctrl.sv - activation-derivative backward-pass sequencer
module deriv_seq_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDR_W:0]  len,
  output logic             busy,
  output logic             done,
  output logic [ADDR_W:0]  sat_cnt,
  deriv_seq_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
    logic              sat;
  } entry_t;

  localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic signed [23:0] POS_3  = 24'sh300000;
  localparam logic signed [23:0] NEG_3  = 24'shD00000;
  localparam logic signed [23:0] POS_1  = 24'sh100000;
  localparam logic signed [23:0] NEG_1  = 24'shF00000;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   sat_cnt_q, sat_cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  entry_t            fifo_q [2];
  entry_t            fifo_d [2];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;

  logic signed [23:0] z_s, g_s;
  logic [23:0]        deriv;
  logic               deriv_sat;
  logic [ADDR_W:0]    len_clamp;
  logic [1:0]         occ;
  logic               wr_accept;
  logic               rd_issue;

  // Piecewise derivative of the returning element; boundaries fall into the inner band.
  always_comb begin
    z_s       = bus.rd_z;
    g_s       = bus.rd_g;
    deriv     = '0;
    deriv_sat = 1'b0;
    if (z_s > POS_3 || z_s < NEG_3) begin
      deriv_sat = 1'b1;
    end else if (z_s > POS_1 || z_s < NEG_1) begin
      deriv = g_s >>> 3;
    end else begin
      deriv = g_s >>> 2;
    end
  end

  assign len_clamp    = (len > LEN_MAX) ? LEN_MAX : len;
  assign occ          = cnt_q + {1'b0, pend_q};
  assign bus.wr_en    = (cnt_q != 2'd0);
  assign bus.wr_addr  = fifo_q[head_q].addr;
  assign bus.wr_data  = fifo_q[head_q].data;
  assign wr_accept    = bus.wr_en && bus.wr_ready;
  // A write leaving this cycle frees the slot a new read would otherwise lack.
  assign rd_issue     = (state_q == S_RUN) && (rd_ptr_q < len_q) &&
                        ((occ < 2'd2) || wr_accept);
  assign bus.rd_en    = rd_issue;
  assign bus.rd_addr  = rd_ptr_q[ADDR_W-1:0];
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_FIN);
  assign sat_cnt      = sat_cnt_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    sat_cnt_d   = sat_cnt_q;
    pend_d      = rd_issue;
    pend_addr_d = rd_ptr_q[ADDR_W-1:0];
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;

    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end

    if (pend_q) begin
      fifo_d[tail_q].addr = pend_addr_q;
      fifo_d[tail_q].data = deriv;
      fifo_d[tail_q].sat  = deriv_sat;
      tail_d              = ~tail_q;
    end

    if (wr_accept) begin
      head_d   = ~head_q;
      wr_ptr_d = wr_ptr_q + ONE;
      if (fifo_q[head_q].sat) begin
        sat_cnt_d = sat_cnt_q + ONE;
      end
    end

    case ({pend_q, wr_accept})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = len_clamp;
          rd_ptr_d  = '0;
          wr_ptr_d  = '0;
          sat_cnt_d = '0;
          state_d   = (len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (wr_accept && (wr_ptr_q + ONE == len_q)) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      sat_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      sat_cnt_q   <= sat_cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: doc/deriv_seq_ctrl.md
# deriv_seq_ctrl

Sequencer for the training-mode backward pass through one layer's activation derivative. On `start` it walks the elements `0..len-1` in order. For each element it reads the stored pre-activation `z` and the incoming gradient `g` from layer memories, applies the piecewise derivative (out = g·f'(z)), and streams the results to a write port with ready/valid backpressure. It sits between the layer's z/gradient RAMs and the delta RAM feeding the previous layer's weight-update engine, and keeps a per-run count of saturated (zeroed) elements.

## Interface
Parameters:
- `ADDR_W`, default 8: element address width; max run length is 2**ADDR_W.

Ports:
- `clk` input 1: the only clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: run request; sampled only in IDLE.
- `len` input ADDR_W+1: element count, captured on accepted `start`; values above 2**ADDR_W are clamped to 2**ADDR_W.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse at the end of a run.
- `rd_en` output 1: read strobe to both z and g memories.
- `rd_addr` output ADDR_W: shared read address.
- `rd_z` input 24: z read data, valid exactly 1 cycle after `rd_en`.
- `rd_g` input 24: g read data, valid exactly 1 cycle after `rd_en`.
- `wr_en` output 1: write valid.
- `wr_ready` input 1: downstream accepts a write when `wr_en && wr_ready`.
- `wr_addr` output ADDR_W: element index of `wr_data`.
- `wr_data` output 24: g·f'(z), signed Q4.20.
- `sat_cnt` output ADDR_W+1: number of elements zeroed by saturation in the current or last run.

## Operation
- Data format: signed Q4.20, 24 bits; 1.0 = 0x100000.
- Derivative, using signed compares:
  - if z > 0x300000 or z < 0xD00000 (|z| > 3.0): out = 0.
  - else if z > 0x100000 or z < 0xF00000 (|z| > 1.0): out = g >>> 3.
  - else: out = g >>> 2.
  - Shifts are arithmetic (sign-extended, truncation toward −inf).
  - Exactly ±3.0 takes the g>>>3 band; exactly ±1.0 takes the g>>>2 band.
- States:
  - IDLE: `start` with len≠0 goes to RUN; it clears `sat_cnt`, resets the read and write pointers to 0 and latches `len`. `start` with len=0 goes to FIN with no reads.
  - RUN: issues reads, computes results, and writes them back. After the write of element len−1 is accepted, goes to FIN.
  - FIN: asserts `done` for one cycle, then goes to IDLE.
  - `busy` = (state == RUN).
- Result buffer:
  - 2-entry FIFO of {addr, data}; an entry is pushed one cycle after its `rd_en` (registered compute).
  - Occupancy counts outstanding reads plus buffered entries and never exceeds 2.
- Read issue: `rd_en` = RUN && rd_ptr < len && (occupancy < 2 || a write is accepted this cycle). `rd_ptr` increments on each `rd_en`.
- Write port:
  - `wr_en` = FIFO non-empty; `wr_data`/`wr_addr` are the FIFO head.
  - Head is held stable while `wr_en && !wr_ready`.
  - Results are written in strictly increasing address order; none are dropped or duplicated.
- `sat_cnt` increments when a zero-band element's write is accepted. It holds after `done` until the next accepted `start`.
- `start` while not IDLE is ignored.
- `rst` at any time:
  - state goes to IDLE and the FIFO and outstanding reads are discarded;
  - `busy`, `done`, `rd_en` and `wr_en` go to 0;
  - `rd_addr`, `wr_addr`, `wr_data` and `sat_cnt` go to 0;
  - read data arriving the cycle after reset is ignored.

## Timing
- Reset values: every output is 0.
- `start` is accepted in cycle T:
  - first `rd_en` (addr 0) in T+1;
  - data captured at the end of T+2;
  - first `wr_en` in T+3.
- With `wr_ready` held high: one read and one write per cycle sustained.
  - Reads occur in T+1..T+len; writes in T+3..T+len+2.
  - `done` pulses in T+len+3; `busy` is low in that cycle.
- len=0: `done` pulses in T+1; no `rd_en`, no `wr_en`, `busy` never asserts.
- Backpressure: no new read issues while occupancy is 2 and no write is accepted.
  - Throughput resumes at 1/cycle the cycle `wr_ready` returns.
- `rd_en` depends combinationally on `wr_ready`; no other input-to-output combinational path exists.

## Test plan
- Basic run, len=4, z={0x080000, 0x180000, 0x380000, 0xC80000}, g=0x100000 for all, wr_ready=1 -> writes addr 0..3 with data {0x040000, 0x020000, 0x000000, 0x000000} in T+3..T+6; `done` in T+7; `sat_cnt`=2.
- Boundaries, z={0x100000, 0xF00000, 0x300000, 0xD00000}, g=0xFFFFF9 (−7) -> data {0xFFFFFE, 0xFFFFFE, 0xFFFFFF, 0xFFFFFF}; `sat_cnt`=0.
- Backpressure, len=8, wr_ready low in T+4..T+6 -> `wr_en` stays high with addr/data stable; at most 2 elements are read ahead of the stalled write; all 8 are written in order; `done` 3 cycles later than in the unstalled case.
- Zero length and clamp:
  - len=0 -> `done` at T+1, no memory traffic.
  - len=2**ADDR_W+5 -> exactly 2**ADDR_W writes, last addr 2**ADDR_W−1.
- Control edge cases:
  - `start` pulsed during RUN -> ignored; the run completes unchanged.
  - `rst` asserted at T+4 of a len=8 run -> next cycle all outputs are 0 and state is IDLE; a following len=3 run produces exactly 3 writes at addr 0..2.
- Full-range run, len=256, random z/g checked against the signed model, with random `wr_ready` -> every element is written exactly once in order; `sat_cnt` matches the model.
